alu_share_ctrl: RTL and testbench

Sequencer and arbiter that shares the single combinational integer ALU between two requesters (req0 = integer execute, req1 = address/aux unit). Accepts one operation at a time via valid/ready and registers operands into the ALU. Captures the ALU result one cycle later and returns it on a tagged response channel. Guards the ALU against illegal opcodes and masks shift amounts to RV32 semantics.

---
 rtl/alu_share_ctrl.sv | 119 +++++++++++
 tb/tb_alu_share_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters; each op takes 2 cycles from accept to response.
// Requesters wait (ready low) while an op is in flight or a response is held by the consumer.
module alu_share_ctrl #(
  parameter int XLEN    = 32,
  parameter int OPW     = 6,
  parameter int NUM_OPS = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [OPW-1:0]  req0_op,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [OPW-1:0]  req1_op,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  output logic [OPW-1:0]  alu_control,
  output logic [XLEN-1:0] alu_rs1,
  output logic [XLEN-1:0] alu_rs2,
  input  logic [XLEN-1:0] alu_result,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [XLEN-1:0] rsp_result,
  output logic            rsp_err,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [OPW-1:0] OP_SLL    = OPW'(6);
  localparam logic [OPW-1:0] OP_SRL    = OPW'(7);
  localparam logic [OPW-1:0] OP_SRA    = OPW'(9);
  localparam logic [OPW-1:0] NUM_OPS_W = OPW'(NUM_OPS);

  state_t          state, state_nxt;
  logic            rr_ptr;
  logic            id_q;
  logic [OPW-1:0]  op_q;
  logic [XLEN-1:0] a_q, b_q;
  logic            rsp_id_q, rsp_err_q;
  logic [XLEN-1:0] rsp_result_q;

  logic both_vld, grant, can_accept, accept, op_legal, is_shift;

  // On a tie the requester that was not served last wins
  assign both_vld   = req0_valid & req1_valid;
  assign grant      = both_vld ? ~rr_ptr : req1_valid;
  assign can_accept = ~rst & ((state == IDLE) | ((state == RESP) & rsp_ready));
  assign req0_ready = can_accept & req0_valid & ~grant;
  assign req1_ready = can_accept & req1_valid & grant;
  assign accept     = req0_ready | req1_ready;

  assign op_legal = op_q < NUM_OPS_W;
  assign is_shift = (op_q == OP_SLL) | (op_q == OP_SRL) | (op_q == OP_SRA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = accept ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ALU inputs come only from registers; illegal ops feed the ALU all zeros
  always_comb begin
    alu_control = '0;
    alu_rs1     = '0;
    alu_rs2     = '0;
    if (op_legal) begin
      alu_control = op_q;
      alu_rs1     = a_q;
      alu_rs2     = is_shift ? {{(XLEN-5){1'b0}}, b_q[4:0]} : b_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr       <= 1'b1;
      id_q         <= 1'b0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_id_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_result_q <= '0;
    end else begin
      if (accept) begin
        op_q   <= grant ? req1_op : req0_op;
        a_q    <= grant ? req1_a  : req0_a;
        b_q    <= grant ? req1_b  : req0_b;
        id_q   <= grant;
        rr_ptr <= grant;
      end
      if (state == EXEC) begin
        rsp_result_q <= op_legal ? alu_result : '0;
        rsp_err_q    <= ~op_legal;
        rsp_id_q     <= id_q;
      end
    end
  end

  assign rsp_valid  = (state == RESP);
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: behavioural ALU, directed vector table, corner sequences, random traffic vs a queue model.
module tb_alu_share_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [5:0]  req0_op, req1_op, alu_control;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [31:0] alu_rs1, alu_rs2, alu_result, rsp_result;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.XLEN(32), .OPW(6), .NUM_OPS(10)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_control(alu_control), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_err(rsp_err), .busy(busy)
  );

  // ALU that shifts by the full rs2 value, so an unmasked shift amount shows up in the result
  always_comb begin
    case (alu_control)
      6'd0:    alu_result = alu_rs1 + alu_rs2;
      6'd1:    alu_result = {31'd0, $signed(alu_rs1) < $signed(alu_rs2)};
      6'd2:    alu_result = {31'd0, alu_rs1 < alu_rs2};
      6'd3:    alu_result = alu_rs1 & alu_rs2;
      6'd4:    alu_result = alu_rs1 | alu_rs2;
      6'd5:    alu_result = alu_rs1 ^ alu_rs2;
      6'd6:    alu_result = alu_rs1 << alu_rs2;
      6'd7:    alu_result = alu_rs1 >> alu_rs2;
      6'd8:    alu_result = alu_rs1 - alu_rs2;
      6'd9:    alu_result = $signed(alu_rs1) >>> alu_rs2;
      default: alu_result = 32'hDEADBEEF;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: {err, result} from RV32 rules on the original operands
  function automatic logic [32:0] ref_rsp(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      6'd0:    return {1'b0, a + b};
      6'd1:    return {1'b0, 31'd0, $signed(a) < $signed(b)};
      6'd2:    return {1'b0, 31'd0, a < b};
      6'd3:    return {1'b0, a & b};
      6'd4:    return {1'b0, a | b};
      6'd5:    return {1'b0, a ^ b};
      6'd6:    return {1'b0, a << sh};
      6'd7:    return {1'b0, a >> sh};
      6'd8:    return {1'b0, a - b};
      6'd9:    return {1'b0, 32'($signed(a) >>> sh)};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  function automatic logic [31:0] ref_rs2(input logic [5:0] op, input logic [31:0] b);
    if (op > 6'd9) return 32'd0;
    if (op == 6'd6 || op == 6'd7 || op == 6'd9) return b & 32'h1F;
    return b;
  endfunction

  // Scoreboard: each accepted op owes a response two cycles after its accept cycle
  typedef struct { logic id; logic err; logic [31:0] res; int due; } exp_t;
  exp_t        exp_q[$];
  int          cyc = 0;
  logic        last_id = 1'b1;
  bit          xp = 0;
  logic [5:0]  x_ctrl;
  logic [31:0] x_rs1, x_rs2;

  always @(negedge clk) begin
    logic exp_rv, can_acc, g, e0, e1;
    logic [5:0] op;
    logic [31:0] a, b;
    logic [32:0] r;
    exp_t n;
    if (rst) begin
      exp_q.delete();
      last_id = 1'b1;
      xp = 0;
    end else begin
      exp_rv = (exp_q.size() > 0) && (cyc >= exp_q[0].due);
      chk("mon_rsp_valid", rsp_valid, exp_rv);
      chk("mon_busy", busy, exp_q.size() > 0);
      if (xp) begin
        chk("mon_alu_control", alu_control, x_ctrl);
        chk("mon_alu_rs1", alu_rs1, x_rs1);
        chk("mon_alu_rs2", alu_rs2, x_rs2);
        xp = 0;
      end
      can_acc = (exp_q.size() == 0) || (exp_rv && rsp_ready);
      g  = (req0_valid && req1_valid) ? ~last_id : req1_valid;
      e0 = can_acc && req0_valid && !g;
      e1 = can_acc && req1_valid && g;
      chk("mon_req0_ready", req0_ready, e0);
      chk("mon_req1_ready", req1_ready, e1);
      if (exp_rv && rsp_ready) begin
        chk("mon_rsp_id", rsp_id, exp_q[0].id);
        chk("mon_rsp_result", rsp_result, exp_q[0].res);
        chk("mon_rsp_err", rsp_err, exp_q[0].err);
        void'(exp_q.pop_front());
      end
      if (e0 || e1) begin
        op = g ? req1_op : req0_op;
        a  = g ? req1_a  : req0_a;
        b  = g ? req1_b  : req0_b;
        r  = ref_rsp(op, a, b);
        n.id = g; n.err = r[32]; n.res = r[31:0]; n.due = cyc + 2;
        exp_q.push_back(n);
        last_id = g;
        xp = 1;
        x_ctrl = r[32] ? 6'd0 : op;
        x_rs1  = r[32] ? 32'd0 : a;
        x_rs2  = ref_rs2(op, b);
      end
    end
    cyc++;
  end

  typedef struct {
    logic id; logic [5:0] op; logic [31:0] a, b, res; logic err; logic [5:0] ctrl; logic [31:0] rs2;
  } vec_t;
  vec_t vt[10];

  task automatic wait_rdy(input logic id, output int w);
    for (w = 0; w < 20; w++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) break;
    end
    chk("ready_timeout", w < 20, 1'b1);
  endtask

  task automatic drive(input logic id, input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    if (id) begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int w;
    @(posedge clk); #1;
    drive(v.id, v.op, v.a, v.b);
    wait_rdy(v.id, w);
    chk($sformatf("vec%0d_ready_wait", idx), w, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("vec%0d_alu_control", idx), alu_control, v.ctrl);
    chk($sformatf("vec%0d_alu_rs1", idx), alu_rs1, v.err ? 32'd0 : v.a);
    chk($sformatf("vec%0d_alu_rs2", idx), alu_rs2, v.rs2);
    chk($sformatf("vec%0d_rsp_early", idx), rsp_valid, 1'b0);
    @(negedge clk);
    chk($sformatf("vec%0d_rsp_valid", idx), rsp_valid, 1'b1);
    chk($sformatf("vec%0d_rsp_id", idx), rsp_id, v.id);
    chk($sformatf("vec%0d_rsp_result", idx), rsp_result, v.res);
    chk($sformatf("vec%0d_rsp_err", idx), rsp_err, v.err);
  endtask

  initial begin
    int w;
    bit a0, a1;
    logic g[$];

    vt[0] = '{1'b0, 6'd0,  32'd5,        32'd7,     32'd12,         1'b0, 6'd0, 32'd7};
    vt[1] = '{1'b1, 6'd6,  32'd1,        32'h23,    32'd8,          1'b0, 6'd6, 32'd3};
    vt[2] = '{1'b0, 6'd9,  32'h80000000, 32'h21,    32'hC0000000,   1'b0, 6'd9, 32'd1};
    vt[3] = '{1'b0, 6'd12, 32'd1234,     32'd5678,  32'd0,          1'b1, 6'd0, 32'd0};
    vt[4] = '{1'b1, 6'd1,  32'hFFFFFFFF, 32'd1,     32'd1,          1'b0, 6'd1, 32'd1};
    vt[5] = '{1'b0, 6'd2,  32'hFFFFFFFF, 32'd1,     32'd0,          1'b0, 6'd2, 32'd1};
    vt[6] = '{1'b1, 6'd7,  32'h80000000, 32'h1F,    32'd1,          1'b0, 6'd7, 32'h1F};
    vt[7] = '{1'b0, 6'd8,  32'd3,        32'd5,     32'hFFFFFFFE,   1'b0, 6'd8, 32'd5};
    vt[8] = '{1'b0, 6'd63, 32'd7,        32'd7,     32'd0,          1'b1, 6'd0, 32'd0};
    vt[9] = '{1'b1, 6'd3,  32'h0000F0F0, 32'hFF00,  32'h0000F000,   1'b0, 6'd3, 32'hFF00};

    rst = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0;
    #3;
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_req0_ready", req0_ready, 1'b0);
    chk("reset_alu_control", alu_control, 6'd0);
    chk("reset_alu_rs1", alu_rs1, 32'd0);
    chk("reset_alu_rs2", alu_rs2, 32'd0);
    chk("reset_rsp_result", rsp_result, 32'd0);
    chk("reset_rsp_id", rsp_id, 1'b0);
    chk("reset_rsp_err", rsp_err, 1'b0);
    req0_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(vt[i], i);

    // Both requesters valid every cycle: grants must alternate starting with req0
    @(posedge clk); #1;
    drive(1'b0, 6'd8, 32'd10, 32'd3);
    drive(1'b1, 6'd5, 32'hF0, 32'h0F);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (req0_ready) g.push_back(1'b0);
      if (req1_ready) g.push_back(1'b1);
    end
    chk("tie_grant_count", g.size(), 4);
    for (int i = 0; i < g.size() && i < 4; i++)
      chk($sformatf("tie_grant%0d", i), g[i], i[0]);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) @(negedge clk);

    // Response held by consumer while req1 waits
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    drive(1'b0, 6'd0, 32'h11, 32'h22);
    wait_rdy(1'b0, w);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    drive(1'b1, 6'd4, 32'd1, 32'd2);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", rsp_valid, 1'b1);
      chk("hold_rsp_result", rsp_result, 32'h33);
      chk("hold_rsp_id", rsp_id, 1'b0);
      chk("hold_rsp_err", rsp_err, 1'b0);
      chk("hold_req1_ready", req1_ready, 1'b0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("hold_accept_same_cycle", req1_ready, 1'b1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(negedge clk);
    chk("hold_next_exec", rsp_valid, 1'b0);
    @(negedge clk);
    chk("hold_next_rsp_valid", rsp_valid, 1'b1);
    chk("hold_next_rsp_id", rsp_id, 1'b1);
    chk("hold_next_rsp_result", rsp_result, 32'd3);
    repeat (2) @(negedge clk);

    // Reset asserted while req0 AND is executing
    @(posedge clk); #1;
    drive(1'b0, 6'd3, 32'hFF, 32'h0F);
    wait_rdy(1'b0, w);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    chk("rst_pre_busy", busy, 1'b1);
    #1;
    drive(1'b0, 6'd0, 32'd1, 32'd1);
    drive(1'b1, 6'd0, 32'd2, 32'd2);
    rst = 1'b1;
    #1;
    chk("rst_mid_rsp_valid", rsp_valid, 1'b0);
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_req0_ready", req0_ready, 1'b0);
    chk("rst_mid_req1_ready", req1_ready, 1'b0);
    chk("rst_mid_alu_control", alu_control, 6'd0);
    chk("rst_mid_alu_rs1", alu_rs1, 32'd0);
    chk("rst_mid_alu_rs2", alu_rs2, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_first_tie_req0", req0_ready, 1'b1);
    chk("rst_first_tie_req1", req1_ready, 1'b0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (4) @(negedge clk);

    // Random traffic; a requester holds its op until accepted
    @(posedge clk); #1;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      a0 = req0_valid & req0_ready;
      a1 = req1_valid & req1_ready;
      @(posedge clk); #1;
      if (a0 || !req0_valid) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'($urandom_range(0, 9));
        req0_a = $urandom; req0_b = $urandom;
      end
      if (a1 || !req1_valid) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'($urandom_range(0, 9));
        req1_a = $urandom; req1_b = $urandom;
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    repeat (6) @(negedge clk);
    chk("final_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
